// File: rtl/mini_src_control_seq.sv
// mini_src_control_seq: hardwired Moore fetch/decode/execute sequencer for the Mini SRC datapath.
// Define MINISRC_BRANCH_EN to add the br (10011) execute sequence; otherwise 10011 decodes as illegal.
module mini_src_control_seq #(
   parameter int OPW = 5
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic [31:0]    IR,
   input  logic           mem_ready,
   input  logic           stop,
   input  logic           con_ff,
   output logic           PCout,
   output logic           PCin,
   output logic           IncPC,
   output logic           MARin,
   output logic           MDRin,
   output logic           MDRout,
   output logic           IRin,
   output logic           Yin,
   output logic           Zin,
   output logic           Zlowout,
   output logic           Cout,
   output logic           CONin,
   output logic           Read,
   output logic           Write,
   output logic           Gra,
   output logic           Grb,
   output logic           Grc,
   output logic           Rin,
   output logic           Rout,
   output logic           BAout,
   output logic [OPW-1:0] alu_op,
   output logic           run,
   output logic           illegal
);
   typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, T8, HALT} state_t;
   typedef struct packed {
      logic           pc_out;
      logic           pc_in;
      logic           inc_pc;
      logic           mar_in;
      logic           mdr_in;
      logic           mdr_out;
      logic           ir_in;
      logic           y_in;
      logic           z_in;
      logic           zlow_out;
      logic           c_out;
      logic           con_in;
      logic           rd;
      logic           wr;
      logic           gra;
      logic           grb;
      logic           grc;
      logic           r_in;
      logic           r_out;
      logic           ba_out;
      logic [OPW-1:0] alu;
      logic           run;
   } ctl_t;

   localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
   localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
   localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
   localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
   localparam logic [OPW-1:0] OP_AND  = OPW'(5'b01010);
   localparam logic [OPW-1:0] OP_OR   = OPW'(5'b01011);
   localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
   localparam logic [OPW-1:0] OP_ANDI = OPW'(5'b01101);
   localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01110);
   localparam logic [OPW-1:0] OP_BR   = OPW'(5'b10011);
   localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
   localparam logic [OPW-1:0] OP_HLT  = OPW'(5'b11011);

   state_t         state, nxt_raw, nxt;
   ctl_t           ctl, d;
   logic [OPW-1:0] op, op_n, imm_alu;
   logic           is_r, is_imm, is_ldi, is_ld, is_st, is_nop, is_hlt, is_br, legal;
   logic           unused_ir;

   assign unused_ir = ^IR[31-OPW:0];

   // op_n is the opcode the next state will execute under: IR while leaving T3, the latched copy after.
   always_comb begin
      op_n    = (state == T3) ? IR[31 -: OPW] : op;
      is_r    = (op_n >= OP_ADD) && (op_n <= OP_OR);
      is_imm  = (op_n >= OP_ADDI) && (op_n <= OP_ORI);
      is_ldi  = op_n == OP_LDI;
      is_ld   = op_n == OP_LD;
      is_st   = op_n == OP_ST;
      is_nop  = op_n == OP_NOP;
      is_hlt  = op_n == OP_HLT;
`ifdef MINISRC_BRANCH_EN
      is_br   = op_n == OP_BR;
`else
      is_br   = 1'b0;
`endif
      legal   = is_r | is_imm | is_ldi | is_ld | is_st | is_nop | is_hlt | is_br;
      imm_alu = is_r ? op_n : (op_n == OP_ANDI) ? OP_AND : (op_n == OP_ORI) ? OP_OR : OP_ADD;
      case (state)
         RST:     nxt_raw = T0;
         T0:      nxt_raw = T1;
         T1:      nxt_raw = T2;
         T2:      nxt_raw = mem_ready ? T3 : T2;
         T3:      nxt_raw = is_hlt ? HALT : (is_nop | ~legal) ? T0 : T4;
         T4:      nxt_raw = T5;
         T5:      nxt_raw = T6;
         T6:      nxt_raw = (is_ld | is_st | is_br) ? T7 : T0;
         T7:      nxt_raw = is_br ? T0 : is_st ? T8 : mem_ready ? T8 : T7;
         T8:      nxt_raw = (is_ld | mem_ready) ? T0 : T8;
         HALT:    nxt_raw = HALT;
         default: nxt_raw = RST;
      endcase
      nxt = (nxt_raw == T0 && stop) ? HALT : nxt_raw;
      d = '0;
      case (nxt)
         T0: begin
            d.pc_out = 1'b1;
            d.mar_in = 1'b1;
            d.inc_pc = 1'b1;
            d.z_in   = 1'b1;
         end
         T1: begin
            d.zlow_out = 1'b1;
            d.pc_in    = 1'b1;
         end
         T2: begin
            d.rd     = 1'b1;
            d.mdr_in = 1'b1;
         end
         T3: begin
            d.mdr_out = 1'b1;
            d.ir_in   = 1'b1;
         end
         T4: begin
            d.gra    = is_br;
            d.con_in = is_br;
            d.grb    = ~is_br;
            d.ba_out = is_ld | is_ldi | is_st;
            d.r_out  = is_br | is_r | is_imm;
            d.y_in   = ~is_br;
         end
         T5: begin
            d.pc_out = is_br;
            d.y_in   = is_br;
            d.grc    = is_r;
            d.r_out  = is_r;
            d.c_out  = ~is_br & ~is_r;
            d.z_in   = ~is_br;
            d.alu    = is_br ? '0 : imm_alu;
         end
         T6: begin
            d.c_out    = is_br;
            d.z_in     = is_br;
            d.alu      = is_br ? OP_ADD : '0;
            d.zlow_out = ~is_br;
            d.mar_in   = is_ld | is_st;
            d.gra      = ~is_br & ~is_ld & ~is_st;
            d.r_in     = ~is_br & ~is_ld & ~is_st;
         end
         T7: begin
            d.zlow_out = is_br;
            d.pc_in    = is_br & con_ff;
            d.rd       = is_ld;
            d.mdr_in   = ~is_br;
            d.gra      = is_st;
            d.r_out    = is_st;
         end
         T8: begin
            d.mdr_out = is_ld;
            d.gra     = is_ld;
            d.r_in    = is_ld;
            d.wr      = ~is_ld;
         end
         default: d = '0;
      endcase
      d.run = (nxt != RST) && (nxt != HALT);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state   <= RST;
         ctl     <= '0;
         op      <= '0;
         illegal <= 1'b0;
      end else begin
         state <= nxt;
         ctl   <= d;
         op    <= op_n;
         if (state == T3 && !legal)
            illegal <= 1'b1;
      end
   end

   assign {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout, CONin,
           Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, alu_op, run} = ctl;
endmodule

// File: tb/tb_mini_src_control_seq.sv
// tb_mini_src_control_seq: cycle-by-cycle directed vectors for the Mini SRC control sequencer.
module tb_mini_src_control_seq;
   logic        clock, reset_n, mem_ready, stop, con_ff;
   logic [31:0] IR;
   logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout, CONin;
   logic        Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, run, illegal;
   logic [4:0]  alu_op;
   logic [26:0] obs;

   mini_src_control_seq #(.OPW(5)) dut (
      .clock(clock), .reset_n(reset_n), .IR(IR), .mem_ready(mem_ready), .stop(stop), .con_ff(con_ff),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
      .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout), .CONin(CONin),
      .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
      .BAout(BAout), .alu_op(alu_op), .run(run), .illegal(illegal)
   );

   assign obs = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout, CONin,
                 Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, alu_op, run, illegal};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   localparam logic [26:0] PCO  = 27'h1 << 26, PCI = 27'h1 << 25, INC = 27'h1 << 24, MAR = 27'h1 << 23;
   localparam logic [26:0] MDI  = 27'h1 << 22, MDO = 27'h1 << 21, IRI = 27'h1 << 20, YIN = 27'h1 << 19;
   localparam logic [26:0] ZIN  = 27'h1 << 18, ZLO = 27'h1 << 17, COUT = 27'h1 << 16, CONI = 27'h1 << 15;
   localparam logic [26:0] RD   = 27'h1 << 14, WR = 27'h1 << 13, GRA = 27'h1 << 12, GRB = 27'h1 << 11;
   localparam logic [26:0] GRC  = 27'h1 << 10, RIN = 27'h1 << 9, ROUT = 27'h1 << 8, BAO = 27'h1 << 7;
   localparam logic [26:0] RUN  = 27'h2, ILL = 27'h1;
   localparam logic [26:0] F0 = PCO | MAR | INC | ZIN | RUN, F1 = ZLO | PCI | RUN;
   localparam logic [26:0] F2 = RD | MDI | RUN, F3 = MDO | IRI | RUN;
   localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010, ADD = 5'b00011, SUB = 5'b00100;
   localparam logic [4:0] ANDI = 5'b01101, ORI = 5'b01110, BR = 5'b10011, NOP = 5'b11010;
   localparam logic [4:0] HLT = 5'b11011, BAD = 5'b11111;

   typedef struct {
      logic        rn;
      logic [4:0]  opc;
      logic        rdy;
      logic        stp;
      logic        con;
      logic [26:0] exp;
   } vec_t;

   vec_t vq[$];
   int   applied = 0;
   int   miscompares = 0;
   bit   live = 0;

   function automatic logic [26:0] alu(input logic [4:0] a);
      return {20'b0, a, 2'b0};
   endfunction

   task automatic step(input vec_t t);
      reset_n   = t.rn;
      IR        = {t.opc, 27'h1918000};
      mem_ready = t.rdy;
      stop      = t.stp;
      con_ff    = t.con;
      @(posedge clock);
      #1;
      applied++;
      if (obs !== t.exp) begin
         miscompares++;
         $display("FAIL vec %0d op=%b: outputs got %h want %h", applied, t.opc, obs, t.exp);
      end
   endtask

   // Queued while building the table, applied immediately once live is set.
   task automatic v(input logic rn, input logic [4:0] o, input logic rdy, input logic s,
                    input logic c, input logic [26:0] e);
      vec_t t;
      t.rn = rn; t.opc = o; t.rdy = rdy; t.stp = s; t.con = c; t.exp = e;
      if (live) step(t);
      else vq.push_back(t);
   endtask

   task automatic fetch(input logic [4:0] o, input logic c, input logic [26:0] x);
      v(1, o, 1, 0, c, F1 | x);
      v(1, o, 1, 0, c, F2 | x);
      v(1, o, 1, 0, c, F3 | x);
   endtask

   initial begin
      reset_n = 0; IR = '0; mem_ready = 0; stop = 0; con_ff = 0;
      // add: 7 clocks
      v(0, ADD, 1, 0, 0, '0);
      v(1, ADD, 1, 0, 0, F0);
      fetch(ADD, 0, '0);
      v(1, ADD, 1, 0, 0, GRB | ROUT | YIN | RUN);
      v(1, ADD, 1, 0, 0, GRC | ROUT | ZIN | alu(ADD) | RUN);
      v(1, ADD, 1, 0, 0, ZLO | GRA | RIN | RUN);
      v(1, ADD, 1, 0, 0, F0);
      // ld: 4 cycles in T2, 3 in T7, 14 clocks
      v(1, LD, 1, 0, 0, F1);
      v(1, LD, 0, 0, 0, F2);
      v(1, LD, 0, 0, 0, F2);
      v(1, LD, 0, 0, 0, F2);
      v(1, LD, 0, 0, 0, F2);
      v(1, LD, 1, 0, 0, F3);
      v(1, LD, 1, 0, 0, GRB | BAO | YIN | RUN);
      v(1, LD, 1, 0, 0, COUT | ZIN | alu(ADD) | RUN);
      v(1, LD, 1, 0, 0, ZLO | MAR | RUN);
      v(1, LD, 0, 0, 0, RD | MDI | RUN);
      v(1, LD, 0, 0, 0, RD | MDI | RUN);
      v(1, LD, 0, 0, 0, RD | MDI | RUN);
      v(1, LD, 1, 0, 0, MDO | GRA | RIN | RUN);
      v(1, LD, 1, 0, 0, F0);
      // st: Write held in T8 until mem_ready
      fetch(ST, 0, '0);
      v(1, ST, 1, 0, 0, GRB | BAO | YIN | RUN);
      v(1, ST, 1, 0, 0, COUT | ZIN | alu(ADD) | RUN);
      v(1, ST, 0, 0, 0, ZLO | MAR | RUN);
      v(1, ST, 0, 0, 0, GRA | ROUT | MDI | RUN);
      v(1, ST, 0, 0, 0, WR | RUN);
      v(1, ST, 0, 0, 0, WR | RUN);
      v(1, ST, 1, 0, 0, F0);
      // andi / ori
      fetch(ANDI, 0, '0);
      v(1, ANDI, 1, 0, 0, GRB | ROUT | YIN | RUN);
      v(1, ANDI, 1, 0, 0, COUT | ZIN | alu(5'b01010) | RUN);
      v(1, ANDI, 1, 0, 0, ZLO | GRA | RIN | RUN);
      v(1, ANDI, 1, 0, 0, F0);
      fetch(ORI, 0, '0);
      v(1, ORI, 1, 0, 0, GRB | ROUT | YIN | RUN);
      v(1, ORI, 1, 0, 0, COUT | ZIN | alu(5'b01011) | RUN);
      v(1, ORI, 1, 0, 0, ZLO | GRA | RIN | RUN);
      v(1, ORI, 1, 0, 0, F0);
      // sub: stop in T5 ignored, stop on T6->T0 halts
      fetch(SUB, 0, '0);
      v(1, SUB, 1, 0, 0, GRB | ROUT | YIN | RUN);
      v(1, SUB, 1, 0, 0, GRC | ROUT | ZIN | alu(SUB) | RUN);
      v(1, SUB, 1, 1, 0, ZLO | GRA | RIN | RUN);
      v(1, SUB, 1, 1, 0, '0);
      v(1, SUB, 1, 0, 0, '0);
      v(0, SUB, 1, 0, 0, '0);
      // undecoded opcode: sticky illegal survives a nop, cleared by reset
      v(1, BAD, 1, 0, 0, F0);
      fetch(BAD, 0, '0);
      v(1, BAD, 1, 0, 0, F0 | ILL);
      fetch(NOP, 0, ILL);
      v(1, NOP, 1, 0, 0, F0 | ILL);
      v(0, NOP, 1, 0, 0, '0);
      v(1, LD, 1, 0, 0, F0);
      // reset inside the T7 wait
      fetch(LD, 0, '0);
      v(1, LD, 1, 0, 0, GRB | BAO | YIN | RUN);
      v(1, LD, 1, 0, 0, COUT | ZIN | alu(ADD) | RUN);
      v(1, LD, 1, 0, 0, ZLO | MAR | RUN);
      v(1, LD, 0, 0, 0, RD | MDI | RUN);
      v(1, LD, 0, 0, 0, RD | MDI | RUN);
      v(0, LD, 0, 0, 0, '0);
      v(1, LD, 1, 0, 0, F0);
      foreach (vq[i]) step(vq[i]);
      live = 1;
`ifdef MINISRC_BRANCH_EN
      for (int c = 1; c >= 0; c--) begin
         fetch(BR, c[0], '0);
         v(1, BR, 1, 0, c[0], GRA | ROUT | CONI | RUN);
         v(1, BR, 1, 0, c[0], PCO | YIN | RUN);
         v(1, BR, 1, 0, c[0], COUT | ZIN | alu(ADD) | RUN);
         v(1, BR, 1, 0, c[0], ZLO | (c[0] ? PCI : '0) | RUN);
         v(1, BR, 1, 0, c[0], F0);
      end
`else
      fetch(BR, 1, '0);
      v(1, BR, 1, 0, 1, F0 | ILL);
`endif
      // halt: everything quiet until reset
      v(0, HLT, 1, 0, 0, '0);
      v(1, HLT, 1, 0, 0, F0);
      fetch(HLT, 0, '0);
      for (int i = 0; i < 20; i++) v(1, HLT, i[0], i[1], 0, '0);
      v(0, LDI, 1, 0, 0, '0);
      v(1, LDI, 1, 0, 0, F0);
      fetch(LDI, 0, '0);
      v(1, LDI, 1, 0, 0, GRB | BAO | YIN | RUN);
      v(1, LDI, 1, 0, 0, COUT | ZIN | alu(ADD) | RUN);
      v(1, LDI, 1, 0, 0, ZLO | GRA | RIN | RUN);
      v(1, LDI, 1, 0, 0, F0);
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end
endmodule
